// File: rtl/byte_serializer.sv
`default_nettype none
// ============================================================================
// Module      : byte_serializer
// Description : Valid/ready byte intake, LSB-first UART-style framing paced by
//               an external baud counter strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_serializer #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 nRST,
  input  logic                 baud_strobe,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_serial,
  output logic                 busy,
  output logic                 counter_clear,
  output logic                 counter_enable
);

  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] c_last_idx   = IDX_W'(DATA_BITS - 1);
  localparam logic             c_last_stop  = 1'(STOP_BITS - 1);
  localparam logic             c_parity_en  = (PARITY_EN != 0);
  localparam logic             c_parity_odd = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_next;
  logic [IDX_W-1:0]     r_idx;
  logic [IDX_W-1:0]     w_idx_next;
  logic                 r_stop_idx;
  logic                 w_stop_next;
  logic                 r_parity;
  logic                 w_parity_next;
  logic                 r_tx_serial;
  logic                 w_serial_next;
  logic                 r_tx_ready;
  logic                 r_clear;
  logic                 w_tick;

  // The counter is being restarted during the clear cycle, so its strobe is stale.
  assign w_tick = baud_strobe && !r_clear;

  always_comb begin
    w_state_next  = r_state;
    w_shift_next  = r_shift;
    w_idx_next    = r_idx;
    w_stop_next   = r_stop_idx;
    w_parity_next = r_parity;
    w_serial_next = 1'b1;

    case (r_state)
      IDLE: begin
        if (tx_valid && r_tx_ready) begin
          w_state_next  = START;
          w_shift_next  = tx_data;
          w_idx_next    = '0;
          w_stop_next   = 1'b0;
          w_parity_next = (^tx_data) ^ c_parity_odd;
        end
      end
      START: begin
        if (w_tick) w_state_next = DATA;
      end
      DATA: begin
        if (w_tick) begin
          w_shift_next = r_shift >> 1;
          w_idx_next   = r_idx + IDX_W'(1);
          if (r_idx == c_last_idx) w_state_next = c_parity_en ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (w_tick) w_state_next = STOP;
      end
      STOP: begin
        if (w_tick) begin
          if (r_stop_idx == c_last_stop) w_state_next = IDLE;
          else                           w_stop_next  = 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase

    // Line level is registered, so it is derived from the upcoming state.
    case (w_state_next)
      START:   w_serial_next = 1'b0;
      DATA:    w_serial_next = w_shift_next[0];
      PARITY:  w_serial_next = w_parity_next;
      default: w_serial_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_idx       <= '0;
      r_stop_idx  <= 1'b0;
      r_parity    <= 1'b0;
      r_tx_serial <= 1'b1;
      r_tx_ready  <= 1'b1;
      r_clear     <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_shift     <= w_shift_next;
      r_idx       <= w_idx_next;
      r_stop_idx  <= w_stop_next;
      r_parity    <= w_parity_next;
      r_tx_serial <= w_serial_next;
      r_tx_ready  <= (w_state_next == IDLE);
      r_clear     <= (r_state == IDLE) && (w_state_next == START);
    end
  end

  assign tx_serial      = r_tx_serial;
  assign tx_ready       = r_tx_ready;
  assign counter_clear  = r_clear;
  assign busy           = (r_state != IDLE);
  assign counter_enable = (r_state != IDLE);

endmodule
`default_nettype wire

// File: doc/byte_serializer.md
# byte_serializer

Serial transmit stage fed by `flexcounter`. It accepts one byte per valid/ready handshake and shifts it out LSB-first as a UART-style frame (start, data, optional parity, stop) on `tx_serial`. Bit timing comes entirely from the counter's one-cycle `strobe`. The block also drives that counter's `clear` and `enableCounter` inputs.

## Interface
- `DATA_BITS`, default 8: data bits per frame. Legal range is 5–8.
- `PARITY_EN`, default 0: when 1, a parity bit is inserted after the data bits.
- `PARITY_ODD`, default 0: selects odd parity when 1, even parity when 0. Ignored when `PARITY_EN`=0.
- `STOP_BITS`, default 1: number of stop bits. Legal values are 1 and 2.
- `clk`, in, 1: the block's single clock. All logic is on the rising edge.
- `nRST`, in, 1: reset, asynchronous and active-low.
- `baud_strobe`, in, 1: one-cycle pulse from `flexcounter.strobe`. Each pulse marks the end of the current bit period.
- `tx_data`, in, `DATA_BITS`: byte to send. Sampled only on handshake.
- `tx_valid`, in, 1: upstream has a byte available.
- `tx_ready`, out, 1: block can accept a byte. Registered.
- `tx_serial`, out, 1: serial line output. Registered. Idle level is 1.
- `busy`, out, 1: high while a frame is in progress.
- `counter_clear`, out, 1: drives `flexcounter.clear`.
- `counter_enable`, out, 1: drives `flexcounter.enableCounter`.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- **IDLE**
  - `tx_ready`=1, `tx_serial`=1, `busy`=0, `counter_enable`=0.
  - A handshake occurs when `tx_valid` && `tx_ready` at a clock edge.
  - On handshake: latch `tx_data` into the shift register, clear the bit index, and go to START.
- **START**
  - `tx_serial`=0.
  - `counter_clear`=1 for exactly the first START cycle, so the counter restarts and the start bit gets a full period.
  - `baud_strobe` is ignored in that first cycle.
  - On the next `baud_strobe`, go to DATA.
- **DATA**
  - `tx_serial` = shift register bit 0.
  - On each `baud_strobe`: shift right and increment the bit index.
  - After the strobe that ends bit index `DATA_BITS`-1: go to PARITY if `PARITY_EN`, otherwise go to STOP.
- **PARITY**
  - `tx_serial` = XOR of the latched data bits, XOR `PARITY_ODD`.
  - The parity value is computed at latch time and held in a flop.
  - On `baud_strobe`, go to STOP.
- **STOP**
  - `tx_serial`=1.
  - Remains in STOP for `STOP_BITS` strobes, then returns to IDLE.
- `busy`=1 and `counter_enable`=1 in every state except IDLE.
- `tx_ready`=1 only in IDLE. It is never high while `busy`=1.
- `tx_data` and `tx_valid` are ignored outside IDLE. No byte is ever dropped or accepted mid-frame.
- A `baud_strobe` that arrives while in IDLE has no effect.

## Timing
- **Reset.** On asynchronous `nRST` assertion the outputs are forced immediately to:
  - `tx_serial`=1, `tx_ready`=1, `busy`=0, `counter_clear`=0, `counter_enable`=0.
  - FSM returns to IDLE and the shift register is cleared.
  - A reset mid-frame aborts the frame. The line returns high with no glitch to 0.
- **Handshake to start bit.** If the handshake occurs at edge N, then from edge N+1:
  - `tx_serial`=0, `tx_ready`=0, `busy`=1, `counter_clear`=1.
  - `counter_clear` drops at edge N+2.
- **Bit changes.** Each bit boundary takes effect at the edge after the cycle in which `baud_strobe`=1.
- **Frame length.** A frame lasts F = 1 + `DATA_BITS` + `PARITY_EN` + `STOP_BITS` strobes. `tx_ready` returns to 1 at the edge following the final stop strobe.
- **Back-to-back frames.**
  - The earliest next handshake is at the first edge where `tx_ready`=1.
  - This guarantees at least one idle-high cycle between frames, in addition to the full stop period.
- **Strobe with `counter_clear`.** If `baud_strobe` and `counter_clear` are high in the same cycle, the strobe is discarded.
- **Strobe at the same edge as a handshake.** The strobe is discarded. START timing is measured only from the counter clear.
- **Simultaneous strobe and last-bit transition.** The state advance and the shift happen in the same cycle. No bit is skipped or repeated.

## Test plan
- **Basic frame.** Reset, strobe every 16 clks, send 0xA5 with defaults.
  - Required: `tx_serial` bit sequence 0,1,0,1,0,0,1,0,1,1, each bit held 16 clks.
  - Required: `tx_ready` is 0 for the whole frame and returns to 1 one edge after the 10th strobe.
- **Parity.** With `PARITY_EN`=1, send 0xA5 and 0x01.
  - Even parity: parity bit = 0 for 0xA5 and 1 for 0x01.
  - `PARITY_ODD`=1: parity bits invert. Frame is 11 bits.
- **Two stop bits.** With `STOP_BITS`=2 and `tx_valid` held high with 0x00 then 0xFF:
  - Required: a stop-high period of exactly 2 bit periods plus 1 idle cycle before the second start bit.
  - Required: second frame data is 1,1,1,1,1,1,1,1.
- **Counter interface.** On each accept, `counter_clear` pulses for exactly 1 cycle.
  - `counter_enable` is high from the accept edge+1 until the return to IDLE.
  - Strobes injected while IDLE do not move `tx_serial`.
- **Reset mid-frame.** Deassert `nRST` during DATA bit 3 for 2 clks.
  - Required: `tx_serial`=1 and `busy`=0 immediately.
  - Required: after release, `tx_ready`=1 and a new 0x3C frame is correct.
- **5-bit frame.** With `DATA_BITS`=5, send 0x1B.
  - Required sequence: 0,1,1,0,1,1,1. Upper input bits are ignored.
